// File: rtl/router_pkg.sv
// Shared types and header-field constants for the 1x3 router input controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LFD,
        LOAD_HDR,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK,
        DROP
    } state_e;

    localparam logic [1:0]  ADDR_INVALID = 2'b11;
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned N_PORTS      = 3;

endpackage

// File: rtl/router_in_ctrl_if.sv
// Source-side byte stream plus output-FIFO control bundle of the router input controller.
interface router_in_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic                          pkt_valid;
    logic [DATA_W-1:0]             data_in;
    logic                          busy;
    logic [router_pkg::N_PORTS-1:0] fifo_full;
    logic [router_pkg::N_PORTS-1:0] fifo_empty;
    logic [router_pkg::N_PORTS-1:0] read_en;
    logic [router_pkg::N_PORTS-1:0] fifo_we;
    logic [DATA_W-1:0]             fifo_din;
    logic                          lfd_state;
    logic [router_pkg::N_PORTS-1:0] vld_out;
    logic [router_pkg::N_PORTS-1:0] soft_rst;
    logic                          parity_done;
    logic                          err;

    // Controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_en,
        output busy, fifo_we, fifo_din, lfd_state, vld_out, soft_rst, parity_done, err
    );

    // Environment side: source, FIFOs and readers.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_en,
        input  busy, fifo_we, fifo_din, lfd_state, vld_out, soft_rst, parity_done, err
    );

endinterface

// File: rtl/router_timeout.sv
// Per-port reader-stall timer: pulses soft_rst_o after TIMEOUT cycles of unread valid data.
module router_timeout #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned TO_W    = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic vld_i,
    input  logic read_en_i,
    input  logic empty_i,
    output logic soft_rst_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            hit;

    assign hit        = (cnt_q == TO_W'(TIMEOUT));
    assign soft_rst_o = hit;

    always_comb begin
        cnt_d = cnt_q;
        if (read_en_i || empty_i || hit) begin
            cnt_d = '0;
        end else if (vld_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/router_in_ctrl.sv
// Router input controller: header decode, FIFO steering, parity check and stall timeouts.
// Optional ROUTER_PKT_STATS_EN adds saturating packet and parity-error counters.
module router_in_ctrl
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned TO_W    = 5
) (
    input  logic            clk,
    input  logic            rstn,
    router_in_ctrl_if.slave bus
`ifdef ROUTER_PKT_STATS_EN
    ,
    output logic [15:0]     pkt_cnt,
    output logic [15:0]     err_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic [DATA_W-1:0] rxp_q, rxp_d;
    logic [1:0]        addr_q, addr_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [5:0]         hdr_len;
    logic [1:0]         hdr_addr;
    logic [N_PORTS:0]   empty_x, full_x, srst_x;
    logic [N_PORTS-1:0] srst;
    logic               full_a, srst_a;
    logic               busy, wr, lfd, pdone;
    logic [DATA_W-1:0]  din;

    assign hdr_len  = bus.data_in[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_addr = bus.data_in[HDR_ADDR_MSB:0];

    // Padded to four entries so the invalid address indexes a harmless slot.
    assign empty_x = {1'b1, bus.fifo_empty};
    assign full_x  = {1'b0, bus.fifo_full};
    assign srst_x  = {1'b0, srst};
    assign full_a  = full_x[addr_q];
    assign srst_a  = srst_x[addr_q];

    for (genvar i = 0; i < N_PORTS; i++) begin : g_to
        router_timeout #(
            .TIMEOUT (TIMEOUT),
            .TO_W    (TO_W)
        ) u_to (
            .clk        (clk),
            .rstn       (rstn),
            .vld_i      (!bus.fifo_empty[i]),
            .read_en_i  (bus.read_en[i]),
            .empty_i    (bus.fifo_empty[i]),
            .soft_rst_o (srst[i])
        );
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        rxp_d   = rxp_q;
        err_d   = err_q;
        busy    = 1'b1;
        wr      = 1'b0;
        din     = '0;
        lfd     = 1'b0;
        pdone   = 1'b0;

        unique case (state_q)
            DECODE: begin
                busy = 1'b0;
                if (bus.pkt_valid) begin
                    hdr_d  = bus.data_in;
                    addr_d = hdr_addr;
                    cnt_d  = {1'b0, hdr_len};
                    par_d  = bus.data_in;
                    err_d  = 1'b0;
                    if (hdr_addr == ADDR_INVALID) begin
                        cnt_d   = {1'b0, hdr_len} + 7'd1;
                        state_d = DROP;
                    end else if (!empty_x[hdr_addr]) begin
                        state_d = WAIT_EMPTY;
                    end else begin
                        state_d = LFD;
                    end
                end
            end

            WAIT_EMPTY: begin
                if (empty_x[addr_q]) state_d = LFD;
            end

            // A flush before any payload is taken drops len payload bytes plus parity.
            LFD: begin
                if (srst_a) begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = DROP;
                end else begin
                    lfd     = 1'b1;
                    state_d = LOAD_HDR;
                end
            end

            LOAD_HDR: begin
                if (srst_a) begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = DROP;
                end else if (!full_a) begin
                    wr      = 1'b1;
                    din     = hdr_q;
                    state_d = (cnt_q != '0) ? LOAD_DATA : LOAD_PARITY;
                end
            end

            LOAD_DATA: begin
                busy = full_a || srst_a;
                if (srst_a) begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = DROP;
                end else if (bus.pkt_valid && !full_a) begin
                    wr    = 1'b1;
                    din   = bus.data_in;
                    par_d = par_q ^ bus.data_in;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_d = LOAD_PARITY;
                end
            end

            LOAD_PARITY: begin
                busy = full_a || srst_a;
                if (srst_a) begin
                    cnt_d   = 7'd1;
                    state_d = DROP;
                end else if (bus.pkt_valid && !full_a) begin
                    wr      = 1'b1;
                    din     = bus.data_in;
                    rxp_d   = bus.data_in;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                pdone   = 1'b1;
                err_d   = (par_q != rxp_q);
                state_d = DECODE;
            end

            DROP: begin
                busy = 1'b0;
                if (bus.pkt_valid) begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_d = DECODE;
                end
            end

            default: state_d = DECODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= DECODE;
            hdr_q   <= '0;
            par_q   <= '0;
            rxp_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            par_q   <= par_d;
            rxp_q   <= rxp_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.fifo_we     = wr ? (N_PORTS'(1) << addr_q) : '0;
    assign bus.fifo_din    = din;
    assign bus.lfd_state   = lfd;
    assign bus.vld_out     = ~bus.fifo_empty;
    assign bus.soft_rst    = srst;
    assign bus.parity_done = pdone;
    assign bus.err         = err_q;

`ifdef ROUTER_PKT_STATS_EN
    logic [15:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (state_q == CHECK) begin
            if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if ((par_q != rxp_q) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_in_ctrl.sv
// Directed bench for router_in_ctrl: packets, back-pressure, drop, parity and timeouts.
module tb_router_in_ctrl;

    logic clk = 1'b0;
    logic rstn;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    router_in_ctrl_if #(.DATA_W(8)) bus ();

`ifdef ROUTER_PKT_STATS_EN
    logic [15:0] pkt_cnt, err_cnt;
`endif

    router_in_ctrl #(
        .DATA_W  (8),
        .TIMEOUT (30),
        .TO_W    (5)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef ROUTER_PKT_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one source cycle, check the combinational outputs, advance to the next negedge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic eb,
                       input logic [2:0] ew, input logic [7:0] ed, input logic el,
                       input string tag);
        bus.pkt_valid = v;
        bus.data_in   = d;
        #1;
        check($sformatf("%s.busy", tag), 32'(bus.busy), 32'(eb));
        check($sformatf("%s.we", tag), 32'(bus.fifo_we), 32'(ew));
        check($sformatf("%s.din", tag), 32'(bus.fifo_din), 32'(ed));
        check($sformatf("%s.lfd", tag), 32'(bus.lfd_state), 32'(el));
        @(negedge clk);
    endtask

    task automatic check_end(input logic exp_err, input string tag);
        bus.pkt_valid = 1'b0;
        #1;
        check($sformatf("%s.pdone", tag), 32'(bus.parity_done), 32'd1);
        check($sformatf("%s.busy", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s.we", tag), 32'(bus.fifo_we), 32'd0);
        @(negedge clk);
        check($sformatf("%s.pdone_low", tag), 32'(bus.parity_done), 32'd0);
        check($sformatf("%s.err", tag), 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rstn           = 1'b0;
        bus.pkt_valid  = 1'b0;
        bus.data_in    = '0;
        bus.fifo_full  = '0;
        bus.fifo_empty = 3'b111;
        bus.read_en    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.we", 32'(bus.fifo_we), 32'd0);
        check("rst.din", 32'(bus.fifo_din), 32'd0);
        check("rst.lfd", 32'(bus.lfd_state), 32'd0);
        check("rst.srst", 32'(bus.soft_rst), 32'd0);
        check("rst.pdone", 32'(bus.parity_done), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        bus.fifo_empty = 3'b010;
        #1;
        check("rst.vld", 32'(bus.vld_out), 32'h5);
        bus.fifo_empty = 3'b111;
        rstn = 1'b1;
        @(negedge clk);

        // Good packet to port 1: 0D 11 22 33, parity 0D
        cyc(1, 8'h0D, 0, 3'b000, 8'h00, 0, "t1_hdr");
        cyc(1, 8'h11, 1, 3'b000, 8'h00, 1, "t1_lfd");
        cyc(1, 8'h11, 1, 3'b010, 8'h0D, 0, "t1_whdr");
        cyc(1, 8'h11, 0, 3'b010, 8'h11, 0, "t1_d0");
        cyc(1, 8'h22, 0, 3'b010, 8'h22, 0, "t1_d1");
        cyc(1, 8'h33, 0, 3'b010, 8'h33, 0, "t1_d2");
        cyc(1, 8'h0D, 0, 3'b010, 8'h0D, 0, "t1_par");
        check_end(0, "t1_chk");

        // Same packet, bad parity
        cyc(1, 8'h0D, 0, 3'b000, 8'h00, 0, "t2_hdr");
        cyc(1, 8'h11, 1, 3'b000, 8'h00, 1, "t2_lfd");
        cyc(1, 8'h11, 1, 3'b010, 8'h0D, 0, "t2_whdr");
        cyc(1, 8'h11, 0, 3'b010, 8'h11, 0, "t2_d0");
        cyc(1, 8'h22, 0, 3'b010, 8'h22, 0, "t2_d1");
        cyc(1, 8'h33, 0, 3'b010, 8'h33, 0, "t2_d2");
        cyc(1, 8'hFF, 0, 3'b010, 8'hFF, 0, "t2_par");
        check_end(1, "t2_chk");

        // Port 0 busy: wait for empty; err clears on header accept
        bus.fifo_empty = 3'b110;
        cyc(1, 8'h04, 0, 3'b000, 8'h00, 0, "t3_hdr");
        check("t3_err_clr", 32'(bus.err), 32'd0);
        repeat (3) cyc(1, 8'hAA, 1, 3'b000, 8'h00, 0, "t3_wait");
        bus.fifo_empty = 3'b111;
        cyc(1, 8'hAA, 1, 3'b000, 8'h00, 0, "t3_go");
        cyc(1, 8'hAA, 1, 3'b000, 8'h00, 1, "t3_lfd");
        cyc(1, 8'hAA, 1, 3'b001, 8'h04, 0, "t3_whdr");
        cyc(1, 8'hAA, 0, 3'b001, 8'hAA, 0, "t3_d0");
        cyc(1, 8'hAE, 0, 3'b001, 8'hAE, 0, "t3_par");
        check_end(0, "t3_chk");

        // Port 2 with source idle and FIFO-full back-pressure mid-payload
        cyc(1, 8'h0A, 0, 3'b000, 8'h00, 0, "t4_hdr");
        cyc(1, 8'h5A, 1, 3'b000, 8'h00, 1, "t4_lfd");
        cyc(1, 8'h5A, 1, 3'b100, 8'h0A, 0, "t4_whdr");
        cyc(1, 8'h5A, 0, 3'b100, 8'h5A, 0, "t4_d0");
        cyc(0, 8'hA5, 0, 3'b000, 8'h00, 0, "t4_idle");
        bus.fifo_full = 3'b100;
        repeat (4) cyc(1, 8'hA5, 1, 3'b000, 8'h00, 0, "t4_full");
        bus.fifo_full = 3'b000;
        cyc(1, 8'hA5, 0, 3'b100, 8'hA5, 0, "t4_d1");
        cyc(1, 8'hF5, 0, 3'b100, 8'hF5, 0, "t4_par");
        check_end(0, "t4_chk");

        // Timeout on port 1: pulse after 30 unread cycles
        bus.pkt_valid  = 1'b0;
        bus.fifo_empty = 3'b101;
        #1;
        check("t5_vld", 32'(bus.vld_out), 32'h2);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check($sformatf("t5_srst_%0d", i), 32'(bus.soft_rst), (i == 30) ? 32'h2 : 32'h0);
        end
        @(negedge clk);
        check("t5_srst_end", 32'(bus.soft_rst), 32'h0);
        bus.fifo_empty = 3'b111;
        @(negedge clk);

        // Read at cycle 29 restarts the count: no pulse
        bus.fifo_empty = 3'b101;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            check("t5b_srst", 32'(bus.soft_rst), 32'h0);
        end
        bus.read_en = 3'b010;
        @(negedge clk);
        bus.read_en = 3'b000;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("t5b_srst_after", 32'(bus.soft_rst), 32'h0);
        end
        bus.fifo_empty = 3'b111;
        @(negedge clk);

        // Invalid address: 4 bytes swallowed, no writes, then a normal packet
        cyc(1, 8'h0B, 0, 3'b000, 8'h00, 0, "t6_hdr");
        cyc(1, 8'hC1, 0, 3'b000, 8'h00, 0, "t6_drop0");
        cyc(0, 8'hC2, 0, 3'b000, 8'h00, 0, "t6_idle");
        cyc(1, 8'hC2, 0, 3'b000, 8'h00, 0, "t6_drop1");
        cyc(1, 8'hC3, 0, 3'b000, 8'h00, 0, "t6_drop2");
        cyc(1, 8'h01, 0, 3'b000, 8'h00, 0, "t6_hdr2");
        cyc(1, 8'h01, 1, 3'b000, 8'h00, 1, "t6_lfd");
        cyc(1, 8'h01, 1, 3'b010, 8'h01, 0, "t6_whdr");
        cyc(1, 8'h01, 0, 3'b010, 8'h01, 0, "t6_par");
        check_end(0, "t6_chk");

        // Soft reset of the active port mid-payload: rest of packet dropped
        cyc(1, 8'h0D, 0, 3'b000, 8'h00, 0, "t7_hdr");
        cyc(1, 8'h11, 1, 3'b000, 8'h00, 1, "t7_lfd");
        cyc(1, 8'h11, 1, 3'b010, 8'h0D, 0, "t7_whdr");
        cyc(1, 8'h11, 0, 3'b010, 8'h11, 0, "t7_d0");
        bus.fifo_empty = 3'b101;
        for (int i = 1; i <= 30; i++) cyc(0, 8'h22, 0, 3'b000, 8'h00, 0, "t7_stall");
        check("t7_srst", 32'(bus.soft_rst), 32'h2);
        cyc(1, 8'h22, 1, 3'b000, 8'h00, 0, "t7_flush");
        bus.fifo_empty = 3'b111;
        cyc(1, 8'h22, 0, 3'b000, 8'h00, 0, "t7_drop0");
        cyc(1, 8'h33, 0, 3'b000, 8'h00, 0, "t7_drop1");
        cyc(1, 8'h0D, 0, 3'b000, 8'h00, 0, "t7_drop2");
        cyc(1, 8'h01, 0, 3'b000, 8'h00, 0, "t7_hdr2");
        cyc(1, 8'h01, 1, 3'b000, 8'h00, 1, "t7_lfd2");
        cyc(1, 8'h01, 1, 3'b010, 8'h01, 0, "t7_whdr2");
        cyc(1, 8'h01, 0, 3'b010, 8'h01, 0, "t7_par2");
        check_end(0, "t7_chk");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
